// File: rtl/pc_fetch_pkg.sv
// Shared types and default constants for the PC fetch unit.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2,
    S_HALT     = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int          DEF_INC          = 4;

endpackage

// File: rtl/pc_fetch_unit_incrementer.sv
// Sequential-address adder; wraps modulo 2^WIDTH.
module pc_incrementer #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc
);

  assign pc_plus_inc = pc + WIDTH'(INC);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request sequencer: reset, run, one-cycle redirect bubble, halt.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INC          = DEF_INC,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  input  logic             halt,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             fetch_valid,
  output logic             misalign
);

  // INC is a power of two, so the low log2(INC) bits are exactly INC-1.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_d;
  logic             misalign_d;
  logic [WIDTH-1:0] redir_tgt;
  logic             redir_req;

  pc_incrementer #(.WIDTH(WIDTH), .INC(INC)) u_inc (
    .pc          (pc),
    .pc_plus_inc (pc_plus_inc)
  );

  assign fetch_valid = (state_q == S_RUN);
  assign redir_req   = jump | branch_taken;
  assign redir_tgt   = jump ? jump_target : branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RESET;
      pc       <= RESET_VECTOR;
      misalign <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      misalign <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    misalign_d = 1'b0;
    case (state_q)
      S_RESET:    state_d = S_RUN;
      S_RUN: begin
        // Redirects ignore stall and imem_ready; halt and backpressure only gate advance.
        if (redir_req) begin
          state_d = S_REDIRECT;
          if ((redir_tgt & ALIGN_MASK) != '0) begin
            pc_d       = EXC_VECTOR;
            misalign_d = 1'b1;
          end else begin
            pc_d = redir_tgt;
          end
        end else if (halt) begin
          state_d = S_HALT;
        end else if (imem_ready && !stall) begin
          pc_d = pc_plus_inc;
        end
      end
      S_REDIRECT: state_d = S_RUN;
      S_HALT:     if (!halt) state_d = S_RUN;
      default:    state_d = S_RESET;
    endcase
    // Exceptions win from every state.
    if (exc) begin
      state_d    = S_REDIRECT;
      pc_d       = EXC_VECTOR;
      misalign_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EV  = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, exc = 1'b0, halt = 1'b0;
  logic        imem_ready = 1'b1;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, pc_plus_inc;
  logic        fetch_valid, misalign;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exc           (exc),
    .halt          (halt),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .fetch_valid   (fetch_valid),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = just reset, 1 = fetching, 2 = bubble, 3 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc = '0;
  logic        m_mis = 1'b0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RV; m_mode = 0; m_mis = 1'b0; m_init = 1'b1;
    end else begin
      m_mis = 1'b0;
      if (exc) begin
        m_pc = EV; m_mode = 2;
      end else if (m_mode == 1 && (jump || branch_taken)) begin
        tgt = jump ? jump_target : branch_target;
        if (tgt % 4 != 0) begin m_pc = EV; m_mis = 1'b1; end
        else m_pc = tgt;
        m_mode = 2;
      end else if (m_mode == 1 && halt) begin
        m_mode = 3;
      end else if (m_mode == 1) begin
        if (imem_ready && !stall) m_pc = m_pc + 32'd4;
      end else if (m_mode == 3) begin
        if (!halt) m_mode = 1;
      end else begin
        m_mode = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_pc", pc, m_pc);
      chk("model_pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
      chk("model_fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == 1});
      chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic clear_ctl();
    rst = 0; stall = 0; branch_taken = 0; jump = 0; exc = 0; halt = 0; imem_ready = 1;
  endtask

  initial begin
    // Reset sequence
    clear_ctl();
    rst = 1;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    step();
    rst = 0;
    chk("reset_state_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    chk("run0_pc", pc, 32'h0);
    chk("run0_fv", {31'd0, fetch_valid}, 32'd1);
    step();
    chk("run1_pc", pc, 32'h4);
    step();
    chk("run2_pc", pc, 32'h8);

    // Backpressure at 0x10
    step(); step();
    chk("bp_start_pc", pc, 32'h10);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pc", pc, 32'h10);
      chk("bp_hold_fv", {31'd0, fetch_valid}, 32'd1);
    end
    imem_ready = 1;
    step();
    chk("bp_release_pc", pc, 32'h14);

    // Priority: exc over jump over branch, stall ignored
    exc = 1; jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300; stall = 1;
    step();
    clear_ctl();
    chk("prio_pc", pc, EV);
    chk("prio_bubble_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    chk("prio_resume_pc", pc, EV);
    chk("prio_resume_fv", {31'd0, fetch_valid}, 32'd1);
    step();
    chk("prio_adv_pc", pc, EV + 32'd4);

    // Misaligned branch target
    branch_taken = 1; branch_target = 32'h102;
    step();
    clear_ctl();
    chk("mis_pc", pc, EV);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    step();
    chk("mis_clear", {31'd0, misalign}, 32'd0);

    // Wrap at top of address space
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step();
    clear_ctl();
    step();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_ppi", pc_plus_inc, 32'h0);
    step();
    chk("wrap_next_pc", pc, 32'h0);

    // Halt then reset mid-halt
    jump = 1; jump_target = 32'h40;
    step();
    clear_ctl();
    step();
    chk("halt_start_pc", pc, 32'h40);
    halt = 1;
    step();
    chk("halt_pc", pc, 32'h40);
    chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    chk("halt_hold_pc", pc, 32'h40);
    rst = 1;
    step();
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_fv", {31'd0, fetch_valid}, 32'd0);
    clear_ctl();
    step();
    chk("halt_rst_run_fv", {31'd0, fetch_valid}, 32'd1);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      exc          = ($urandom_range(0, 15) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      halt         = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      imem_ready   = ($urandom_range(0, 3) != 0);
      jump_target   = ($urandom() & 32'hFFFF_FFFC) |
                      (($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
      branch_target = ($urandom() & 32'hFFFF_FFFC) |
                      (($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
      step();
    end
    clear_ctl();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
